// File: rtl/display_arb_pkg.sv
// Shared types and helpers for the display arbiter and its round-robin picker.
// No logic here: state encoding, requester limit and index-width helper.
package display_arb_pkg;

    typedef enum logic {IDLE, SHOW} arb_state_t;

    localparam int MAX_REQ = 8;

    // Index width that never collapses to zero bits for tiny requester counts.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/display_arbiter_rr_picker.sv
// Combinational rotate-priority encoder: first set request above i_ptr, wrapping.
// Zero latency; i_excl removes the i_ptr slot itself from the search.
import display_arb_pkg::*;

module rr_picker #(
    parameter int N     = 4,
    parameter int IDX_W = clog2_min1(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    input  logic             i_excl,
    output logic             o_found,
    output logic [IDX_W-1:0] o_idx,
    output logic [N-1:0]     o_onehot
);

    localparam logic [N-1:0] ONE = N'(1);

    int               w_c;
    logic [IDX_W-1:0] w_ci;

    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_c     = 0;
        w_ci    = '0;
        // k = N lands back on i_ptr, so the previous owner is always last in line.
        for (int k = 1; k <= N; k++) begin
            w_c  = (int'(i_ptr) + k) % N;
            w_ci = w_c[IDX_W-1:0];
            if (!o_found && i_req[w_ci] && !(i_excl && (w_ci == i_ptr))) begin
                o_found = 1'b1;
                o_idx   = w_ci;
            end
        end
    end

    assign o_onehot = o_found ? (ONE << o_idx) : '0;

endmodule

// File: rtl/display_arbiter.sv
// Round-robin owner of the 16-bit hex display path with a minimum dwell per grant.
// Outputs registered, one cycle after the sampling edge; i_lock freezes dwell and grant.
import display_arb_pkg::*;

module display_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 16,
    parameter int DWELL_CYCLES = 50000000
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [NUM_REQ-1:0]          i_req,
    input  logic [NUM_REQ*DATA_W-1:0]   i_data,
    input  logic                        i_lock,
    output logic [DATA_W-1:0]           o_num,
    output logic [NUM_REQ-1:0]          o_grant,
    output logic [clog2_min1(NUM_REQ)-1:0] o_owner,
    output logic [NUM_REQ-1:0]          o_ack,
    output logic                        o_busy
);

    localparam int IDX_W = clog2_min1(NUM_REQ);
    localparam int CNT_W = $clog2(DWELL_CYCLES + 1);
    localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [IDX_W-1:0] PTR_INIT = IDX_W'(NUM_REQ - 1);

    arb_state_t         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_owner;
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] r_ack;
    logic [DATA_W-1:0]  r_num;

    logic [DATA_W-1:0]  w_dat [NUM_REQ];
    logic               w_found;
    logic [IDX_W-1:0]   w_idx;
    logic [NUM_REQ-1:0] w_onehot;
    logic               w_take;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_dat[g] = i_data[g*DATA_W +: DATA_W];
    end

    // In SHOW r_ptr equals the owner, so excluding it means "someone else".
    rr_picker #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .i_req    (i_req),
        .i_ptr    (r_ptr),
        .i_excl   (r_state == SHOW),
        .o_found  (w_found),
        .o_idx    (w_idx),
        .o_onehot (w_onehot)
    );

    assign w_take = !i_lock && w_found &&
                    ((r_state == IDLE) || (r_cnt == '0));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ptr   <= PTR_INIT;
            r_owner <= '0;
            r_grant <= '0;
            r_ack   <= '0;
            r_num   <= '0;
        end else begin
            r_ack <= '0;
            if (r_state == SHOW && i_req[r_owner]) begin
                r_num <= w_dat[r_owner];
            end
            if (w_take) begin
                r_state <= SHOW;
                r_cnt   <= RELOAD;
                r_ptr   <= w_idx;
                r_owner <= w_idx;
                r_grant <= w_onehot;
                r_ack   <= w_onehot;
                r_num   <= w_dat[w_idx];
            end else if (r_state == SHOW && !i_lock) begin
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end else if (i_req[r_owner]) begin
                    r_cnt <= RELOAD;
                end else begin
                    r_state <= IDLE;
                    r_grant <= '0;
                end
            end
        end
    end

    assign o_num   = r_num;
    assign o_grant = r_grant;
    assign o_owner = r_owner;
    assign o_ack   = r_ack;
    assign o_busy  = (r_state == SHOW);

endmodule

// File: tb/tb_display_arbiter.sv
// Randomised and directed bench for display_arbiter against a grant/dwell reference model.
module tb_display_arbiter;

    localparam int NR = 4;
    localparam int DW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [63:0] data = '0;
    logic        lock = 1'b0;
    logic [15:0] o_num;
    logic [3:0]  o_grant;
    logic [1:0]  o_owner;
    logic [3:0]  o_ack;
    logic        o_busy;

    int n_cmp = 0;
    int n_bad = 0;

    display_arbiter #(.NUM_REQ(NR), .DATA_W(16), .DWELL_CYCLES(DW)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_data(data), .i_lock(lock),
        .o_num(o_num), .o_grant(o_grant), .o_owner(o_owner), .o_ack(o_ack), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    // Reference model: who owns the display, how many unlocked cycles it has shown.
    bit          m_valid = 0;
    bit          m_busy  = 0;
    int          m_owner = 0;
    int          m_last  = NR - 1;
    int          m_held  = 0;
    logic [15:0] m_num   = '0;
    logic [3:0]  m_ack   = '0;

    function automatic logic [15:0] dat(input logic [63:0] d, input int k);
        return 16'(d >> (16 * k));
    endfunction

    function automatic int pick(input logic [3:0] r, input int last, input bit not_last);
        for (int k = 1; k <= NR; k++) begin
            int c;
            c = (last + k) % NR;
            if (r[c] && !(not_last && c == last)) return c;
        end
        return -1;
    endfunction

    task automatic m_grant(input int w);
        m_busy  = 1;
        m_owner = w;
        m_last  = w;
        m_held  = 0;
        m_num   = dat(data, w);
        m_ack   = 4'(1 << w);
    endtask

    always @(posedge clk) begin : model
        int w;
        if (rst) begin
            m_valid = 1; m_busy = 0; m_owner = 0; m_last = NR - 1;
            m_held = 0; m_num = '0; m_ack = '0;
        end else begin
            m_ack = '0;
            if (m_busy && req[m_owner]) m_num = dat(data, m_owner);
            if (!lock) begin
                if (!m_busy) begin
                    w = pick(req, m_last, 1'b0);
                    if (w >= 0) m_grant(w);
                end else begin
                    m_held++;
                    if (m_held >= DW) begin
                        w = pick(req, m_owner, 1'b1);
                        if (w >= 0) m_grant(w);
                        else if (req[m_owner]) m_held = 0;
                        else m_busy = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [3:0] eg;
        if (m_valid) begin
            eg = m_busy ? 4'(1 << m_owner) : 4'b0;
            n_cmp++;
            if (o_grant !== eg || o_owner !== 2'(m_owner) || o_num !== m_num ||
                o_ack !== m_ack || o_busy !== m_busy) begin
                n_bad++;
                $display("FAIL model t=%0t got grant=%b owner=%0d num=%h ack=%b busy=%b want grant=%b owner=%0d num=%h ack=%b busy=%0d",
                         $time, o_grant, o_owner, o_num, o_ack, o_busy, eg, m_owner, m_num, m_ack, m_busy);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; req = '0; lock = 1'b0;
        step(n);
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int acks;
        int cnt;
        step(1);
        do_reset(2);
        chk("rst_num", 32'(o_num), 32'h0);
        chk("rst_grant", 32'(o_grant), 32'h0);
        chk("rst_busy", 32'(o_busy), 32'h0);
        chk("rst_ack", 32'(o_ack), 32'h0);
        chk("rst_owner", 32'(o_owner), 32'h0);

        // Single requester, then live update of its value.
        req = 4'b0010; data = 64'h0000_0000_1234_0000;
        step(1);
        chk("g1_grant", 32'(o_grant), 32'h2);
        chk("g1_owner", 32'(o_owner), 32'h1);
        chk("g1_num", 32'(o_num), 32'h1234);
        chk("g1_ack", 32'(o_ack), 32'h2);
        data = 64'h0000_0000_BEEF_0000;
        step(1);
        chk("g1_live", 32'(o_num), 32'hBEEF);
        chk("g1_ack_gone", 32'(o_ack), 32'h0);

        // Two contenders alternate 0,2,0,2 with four cycles each.
        do_reset(1);
        req = 4'b0101;
        acks = 0;
        for (int i = 0; i < 16; i++) begin
            step(1);
            if (o_ack != 0) acks++;
            if (i % 4 == 0) begin
                chk("rr_owner", 32'(o_owner), ((i / 4) % 2 == 1) ? 32'd2 : 32'd0);
                chk("rr_ack", 32'(o_ack), ((i / 4) % 2 == 1) ? 32'h4 : 32'h1);
            end
        end
        chk("rr_ack_count", 32'(acks), 32'd4);

        // Owner drops its request mid-dwell: value freezes, then idle.
        do_reset(1);
        req = 4'b1000; data = 64'h00A5_0000_0000_0000;
        step(3);
        req = 4'b0000; data = 64'hFFFF_1111_2222_3333;
        step(1);
        chk("drop_busy_mid", 32'(o_busy), 32'h1);
        chk("drop_num_mid", 32'(o_num), 32'h00A5);
        step(1);
        chk("drop_grant", 32'(o_grant), 32'h0);
        chk("drop_busy", 32'(o_busy), 32'h0);
        chk("drop_num", 32'(o_num), 32'h00A5);
        chk("drop_owner", 32'(o_owner), 32'h3);

        // Lock for 10 cycles stretches the dwell to 14.
        do_reset(1);
        req = 4'b0001;
        step(1);
        req = 4'b1001;
        cnt = 0;
        for (int n = 0; n < 40 && o_grant == 4'b0001; n++) begin
            cnt++;
            if (n == 1) lock = 1'b1;
            if (n == 11) lock = 1'b0;
            step(1);
        end
        chk("lock_len", 32'(cnt), 32'd14);
        chk("lock_next", 32'(o_grant), 32'h8);

        // Reset mid-dwell returns the round-robin pointer to its start.
        do_reset(1);
        req = 4'b0100;
        step(3);
        req = 4'b0110; rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("mrst_grant", 32'(o_grant), 32'h0);
        chk("mrst_num", 32'(o_num), 32'h0);
        chk("mrst_busy", 32'(o_busy), 32'h0);
        step(1);
        chk("mrst_owner", 32'(o_owner), 32'h1);
        chk("mrst_win", 32'(o_grant), 32'h2);

        // Random traffic with occasional lock and reset.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            data = {$urandom, $urandom};
            if ($urandom_range(0, 9) == 0) lock = ~lock;
            rst = ($urandom_range(0, 399) == 0);
            step(1);
        end
        rst = 1'b0; lock = 1'b0;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/display_arbiter.md
Name: display_arbiter

Overview:
- Shares the board's single 16-bit hex display path between NUM_REQ requesters (qsys-exported counters, UART-decoded values, debug taps).
- Grants the display round-robin and holds each grant for a minimum dwell time so values stay readable.
- Drives the registered 16-bit word that feeds the four SevenHexDecoder instances.
- Supports a freeze input tied to a KEY/SW for inspection.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 16, width of each requester's value and of o_num.
- DWELL_CYCLES, 50000000, minimum grant length in clock cycles (1 s at 50 MHz); must be >= 1.

Ports:
- i_clk  input  1  system clock (CLOCK_50 domain).
- i_rst  input  1  synchronous, active-high reset.
- i_req  input  NUM_REQ  per-requester request level; bit k belongs to requester k.
- i_data  input  NUM_REQ*DATA_W  packed values; requester k occupies bits [k*DATA_W +: DATA_W].
- i_lock  input  1  freeze: dwell counter and grant held while high.
- o_num  output  DATA_W  registered value to display.
- o_grant  output  NUM_REQ  one-hot current owner; all zero when idle.
- o_owner  output  $clog2(NUM_REQ)  index of current owner; holds the last owner when idle.
- o_ack  output  NUM_REQ  one-cycle pulse on the cycle a new grant takes effect.
- o_busy  output  1  high in SHOW.

Behaviour:
- Reset values: o_num=0, o_grant=0, o_owner=0, o_ack=0, o_busy=0, state=IDLE, dwell counter=0, rr_ptr=NUM_REQ-1.
  - With rr_ptr=NUM_REQ-1, requester 0 has top priority first.
- All outputs are registered.
- Round-robin pick: the first asserted request searching upward from rr_ptr+1, modulo NUM_REQ.
- IDLE:
  - If no request is asserted, stay in IDLE; o_num is unchanged.
  - If any request is asserted at edge t, then from edge t+1:
    - o_grant=one-hot(winner), o_owner=winner, o_num=i_data[winner] as sampled at t.
    - o_ack[winner]=1 for that one cycle; counter=DWELL_CYCLES-1; rr_ptr=winner; state goes to SHOW.
- SHOW, each cycle:
  - If i_req[owner] is high, o_num follows i_data[owner] with 1-cycle latency (live update).
  - If i_req[owner] is low, o_num freezes at its last value.
  - If i_lock is high, the counter, grant and state hold.
  - Else if counter != 0, the counter decrements.
  - Else (counter == 0) the dwell expires:
    - If a requester other than the owner is asserted, switch to the round-robin pick. This follows the same rules as the IDLE grant: o_ack pulse, counter reload, rr_ptr update.
    - Else if the owner is still requesting, keep the grant, reload the counter, and do not pulse o_ack.
    - Else go to IDLE: o_grant=0, o_busy=0; o_num and o_owner hold.
- Minimum grant length is exactly DWELL_CYCLES cycles plus any cycles with i_lock high.
- Requests arriving mid-dwell wait; they are never dropped while still asserted (level semantics, no internal queueing).
- A request that deasserts before it is granted is forgotten.
- i_lock high in IDLE: no new grant is issued until i_lock falls.
- i_rst high at any edge, including mid-SHOW: all state returns to reset values at that edge. Reset has priority over all other inputs.
- Counter width: $clog2(DWELL_CYCLES+1). No wrap is possible because the counter only decrements when non-zero.

Decomposition:
- Package display_arb_pkg holds:
  - typedef enum logic {IDLE, SHOW} arb_state_t;
  - localparam MAX_REQ=8;
  - function clog2_min1 for index widths when NUM_REQ=1 or 2.
- Sub-module rr_picker: combinational rotate-priority encoder.
  - Inputs: req vector, rr_ptr, exclude-owner flag.
  - Outputs: found, index, one-hot.
  - Shared with future bus arbiters in the design.

Test Plan (NUM_REQ=4, DATA_W=16, DWELL_CYCLES=4):
- Reset held 2 cycles, no requests -> o_num=0x0000, o_grant=4'b0000, o_busy=0, o_ack=0.
- i_req=4'b0010, data1=0x1234 at edge t -> at t+1: o_grant=4'b0010, o_owner=1, o_num=0x1234, o_ack=4'b0010 for one cycle. Then data1=0xBEEF at t+2 -> o_num=0xBEEF at t+3.
- From reset, i_req=4'b0101 held -> grant sequence 0,2,0,2. Each grant lasts 4 cycles, with a single o_ack pulse per switch.
- Owner 3 (data 0x00A5) drops i_req two cycles into its dwell, no other requests -> o_num stays 0x00A5. At dwell expiry o_grant=0 and o_busy=0; o_num stays 0x00A5 and o_owner stays 3.
- Owner 0 in SHOW, req 3 pending, i_lock high for 10 cycles mid-dwell -> owner 0 holds for 14 cycles total, then grant moves to 3.
- i_rst pulsed for 1 cycle while owner 2 is mid-dwell -> next cycle all outputs at reset values. With req 1 and 2 then asserted, requester 1 wins (rr_ptr reset).
